bus_arbiter: RTL and testbench

- Round-robin arbiter and frame sequencer for the shared 1-bit node bus of the 16-node FPGA network.
- Samples per-node transmit requests and grants the bus to exactly one node.
- Loads that node's frame (source address, receiver address, data, CRC) and shifts it MSB-first onto bus_show.
- Enforces an inter-frame gap, then rotates priority so the granted node drops to lowest priority.

---
 rtl/bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and serial frame sequencer for the shared 1-bit node bus.
// Grants one requester, shifts {grant_id, frame_in} out MSB-first, then idles for a gap.
module bus_arbiter #(
    parameter int N          = 16,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 64,
    parameter int CRC_W      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [N-1:0]                    req,
    input  logic [ADDR_W+DATA_W+CRC_W-1:0]  frame_in,
    output logic [N-1:0]                    grant,
    output logic [ADDR_W-1:0]               grant_id,
    output logic                            busy,
    output logic                            bus_show,
    output logic                            tx_done,
    output logic [ADDR_W-1:0]               tx_id,
    output logic [1:0]                      state_dbg
);

    localparam int FIN_W   = ADDR_W + DATA_W + CRC_W;
    localparam int FRAME_W = ADDR_W + FIN_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [ADDR_W-1:0]  grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic               bus_show_q, bus_show_d;
    logic               tx_done_q, tx_done_d;
    logic [ADDR_W-1:0]  tx_id_q, tx_id_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic [FRAME_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic               arb_found;
    logic [ADDR_W-1:0]  arb_winner;
    logic [ADDR_W:0]    arb_idx;
    logic [FRAME_W-1:0] frame_w;

    assign frame_w = {grant_id_q, frame_in};

    // Search last+1, last+2, ... wrapping, so the last-served node is checked last.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        arb_idx    = '0;
        for (int i = 1; i <= N; i++) begin
            arb_idx = {1'b0, last_q} + (ADDR_W+1)'(i);
            if (arb_idx >= (ADDR_W+1)'(N)) begin
                arb_idx = arb_idx - (ADDR_W+1)'(N);
            end
            if (!arb_found && req[arb_idx[ADDR_W-1:0]]) begin
                arb_found  = 1'b1;
                arb_winner = arb_idx[ADDR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        bus_show_d = bus_show_q;
        tx_done_d  = 1'b0;
        tx_id_d    = tx_id_q;
        last_d     = last_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;

        case (state_q)
            S_IDLE: begin
                bus_show_d = 1'b0;
                if (arb_found) begin
                    grant_d    = {{(N-1){1'b0}}, 1'b1} << arb_winner;
                    grant_id_d = arb_winner;
                    busy_d     = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                // frame_in has had a full cycle to follow grant_id through the external mux.
                bus_show_d = frame_w[FRAME_W-1];
                sreg_d     = {frame_w[FRAME_W-2:0], 1'b0};
                cnt_d      = CNT_W'(1);
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (cnt_q == CNT_W'(FRAME_W)) begin
                    bus_show_d = 1'b0;
                    tx_done_d  = 1'b1;
                    tx_id_d    = grant_id_q;
                    last_d     = grant_id_q;
                    gap_d      = GAP_W'(1);
                    state_d    = S_GAP;
                end else begin
                    bus_show_d = sreg_q[FRAME_W-1];
                    sreg_d     = sreg_q << 1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                bus_show_d = 1'b0;
                if (gap_q == GAP_W'(GAP_CYCLES)) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                grant_d    = '0;
                busy_d     = 1'b0;
                bus_show_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            bus_show_q <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_id_q    <= '0;
            last_q     <= ADDR_W'(N - 1);
            sreg_q     <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            bus_show_q <= bus_show_d;
            tx_done_q  <= tx_done_d;
            tx_id_q    <= tx_id_d;
            last_q     <= last_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
        end
    end

    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign bus_show  = bus_show_q;
    assign tx_done   = tx_done_q;
    assign tx_id     = tx_id_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a frame-timeline model checked every cycle, plus directed
// scenarios with hand-computed grant orders, bit patterns and latencies.
module tb_bus_arbiter;

    localparam int N       = 16;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 64;
    localparam int CRC_W   = 4;
    localparam int GAP     = 1;
    localparam int FIN_W   = ADDR_W + DATA_W + CRC_W;
    localparam int FRAME_W = ADDR_W + FIN_W;
    localparam int DONE_T  = FRAME_W + 1;
    localparam int END_T   = DONE_T + GAP;

    // Valid/ready is not used here: req is a level request, grant/tx_done are registered status.
    logic              clock;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [FIN_W-1:0]  frame_in;
    logic [N-1:0]      grant;
    logic [ADDR_W-1:0] grant_id;
    logic              busy;
    logic              bus_show;
    logic              tx_done;
    logic [ADDR_W-1:0] tx_id;
    logic [1:0]        state_dbg;

    logic [FIN_W-1:0]  frame_tab [N];
    assign frame_in = frame_tab[grant_id];

    bus_arbiter #(
        .N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CRC_W(CRC_W), .GAP_CYCLES(GAP)
    ) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .frame_in(frame_in),
        .grant(grant), .grant_id(grant_id), .busy(busy), .bus_show(bus_show),
        .tx_done(tx_done), .tx_id(tx_id), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clock) cyc++;

    // ---------------- behavioural model ----------------
    // A frame is a timeline counted from its grant edge: t=0 grant, t=1..76 bits,
    // t=77 done pulse, t=77+GAP back to idle.
    logic               m_active = 1'b0;
    int                 m_t = 0;
    int                 m_id = 0;
    int                 m_last = N - 1;
    logic [FRAME_W-1:0] m_frame = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_id     = 0;
            m_last   = N - 1;
            m_frame  = '0;
        end else if (!m_active) begin
            if (req != '0) begin
                bit found;
                found = 1'b0;
                for (int i = 1; i <= N; i++) begin
                    if (!found && req[(m_last + i) % N]) begin
                        found = 1'b1;
                        m_id  = (m_last + i) % N;
                    end
                end
                m_active = 1'b1;
                m_t      = 0;
            end
        end else begin
            m_t++;
            if (m_t == 1) m_frame = {4'(m_id), frame_in};
            if (m_t == DONE_T) m_last = m_id;
            if (m_t == END_T) m_active = 1'b0;
        end
    end

    // ---------------- per-cycle compare and logs ----------------
    logic [N-1:0]      g_log [$];
    int                g_cyc [$];
    logic [ADDR_W-1:0] t_log [$];
    int                t_cyc [$];
    logic [N-1:0]      prev_grant = '0;

    always @(negedge clock) begin
        logic [N-1:0] exp_grant;
        logic         exp_bus;
        logic         exp_done;
        exp_grant = m_active ? ({{(N-1){1'b0}}, 1'b1} << m_id) : '0;
        exp_bus   = (m_active && m_t >= 1 && m_t <= FRAME_W) ? m_frame[FRAME_W - m_t] : 1'b0;
        exp_done  = m_active && (m_t == DONE_T);
        checks++;
        if (grant !== exp_grant || grant_id !== 4'(m_id) || busy !== m_active ||
            bus_show !== exp_bus || tx_done !== exp_done ||
            (exp_done && tx_id !== 4'(m_id))) begin
            errors++;
            $display("FAIL cycle_compare cyc=%0d: got grant=%h id=%0d busy=%b bus=%b done=%b txid=%0d, expected grant=%h id=%0d busy=%b bus=%b done=%b txid=%0d",
                     cyc, grant, grant_id, busy, bus_show, tx_done, tx_id,
                     exp_grant, m_id, m_active, exp_bus, exp_done, m_id);
        end
        if (grant !== '0 && prev_grant === '0) begin
            g_log.push_back(grant);
            g_cyc.push_back(cyc);
        end
        prev_grant = grant;
        if (tx_done === 1'b1) begin
            t_log.push_back(tx_id);
            t_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (grant == '0 && n < 200);
        if (grant == '0) timeout_fail(name);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            step();
            n++;
        end
        if (busy !== 1'b0) timeout_fail(name);
    endtask

    // ---------------- scoreboard for full contention ----------------
    logic [ADDR_W-1:0] exp_q [$];

    initial begin
        int                 k;
        logic [FRAME_W-1:0] cap;
        logic [FRAME_W-1:0] exp_frame;
        logic [N-1:0]       rr_exp [4];
        int                 n;

        reset_n = 1'b0;
        req     = '1;
        for (int i = 0; i < N; i++) frame_tab[i] = {8'($urandom), $urandom, $urandom};

        // Reset with every node requesting.
        repeat (3) step();
        check("reset_grant", grant, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_bus", bus_show, 1'b0);
        check("reset_done", tx_done, 1'b0);
        reset_n = 1'b1;
        wait_grant("first_grant_wait");
        check("first_grant", grant, 16'h0001);
        req = '0;
        wait_idle("first_idle");

        // Single frame from node 0 with a hand-built bit pattern.
        frame_tab[0] = {4'h1, 64'h1, 4'h1};
        exp_frame    = {4'h0, 4'h1, 64'h1, 4'h1};
        req = 16'h0001;
        wait_grant("single_grant_wait");
        check("single_grant", grant, 16'h0001);
        k = cyc;
        req = '0;
        for (int j = 0; j < FRAME_W; j++) begin
            step();
            cap[FRAME_W-1-j] = bus_show;
        end
        check("single_frame_bits", cap, exp_frame);
        step();
        check("single_tx_done", tx_done, 1'b1);
        check("single_tx_id", tx_id, 4'd0);
        check("single_done_latency", cyc - k, 77);
        step();
        check("single_busy_low", busy, 1'b0);
        check("single_grant_low", grant, '0);

        // Request drop mid-SEND plus frame_in change after LOAD.
        req = 16'h0004;
        wait_grant("drop_grant_wait");
        check("drop_grant", grant, 16'h0004);
        k = cyc;
        t_log.delete();
        t_cyc.delete();
        repeat (11) step();
        req = '0;
        frame_tab[2] = ~frame_tab[2];
        wait_idle("drop_idle");
        check("drop_done_count", t_log.size(), 1);
        if (t_log.size() >= 1) begin
            check("drop_tx_id", t_log[0], 4'd2);
            check("drop_done_latency", t_cyc[0] - k, 77);
        end
        check("drop_grant_cleared", grant, '0);

        // Round robin between nodes 0 and 1.
        rr_exp = '{16'h0001, 16'h0002, 16'h0001, 16'h0002};
        g_log.delete();
        g_cyc.delete();
        req = 16'h0003;
        n = 0;
        while (g_log.size() < 4 && n < 400) begin
            step();
            n++;
        end
        req = '0;
        if (g_log.size() < 4) timeout_fail("rr_wait");
        wait_idle("rr_idle");
        for (int i = 0; i < 4; i++) begin
            if (i < g_log.size()) check($sformatf("rr_grant%0d", i), g_log[i], rr_exp[i]);
            if (i > 0 && i < g_cyc.size())
                check($sformatf("rr_spacing%0d", i), g_cyc[i] - g_cyc[i-1], 78 + GAP);
        end

        // Reset during bit 40 of node 5's frame.
        req = 16'h0020;
        wait_grant("mid_grant_wait");
        check("mid_grant", grant, 16'h0020);
        req = '0;
        repeat (41) step();
        t_log.delete();
        #1 reset_n = 1'b0;
        #1;
        check("mid_reset_bus", bus_show, 1'b0);
        check("mid_reset_grant", grant, '0);
        check("mid_reset_busy", busy, 1'b0);
        check("mid_reset_done", tx_done, 1'b0);
        repeat (2) step();
        check("mid_reset_no_done", t_log.size(), 0);
        g_log.delete();
        req = 16'h0021;
        reset_n = 1'b1;
        n = 0;
        while (g_log.size() < 2 && n < 300) begin
            step();
            n++;
        end
        req = '0;
        if (g_log.size() < 2) timeout_fail("post_reset_wait");
        wait_idle("post_reset_idle");
        if (g_log.size() >= 2) begin
            check("post_reset_first", g_log[0], 16'h0001);
            check("post_reset_second", g_log[1], 16'h0020);
        end

        // Serve node 15 so full contention starts from node 0.
        req = 16'h8000;
        wait_grant("n15_grant_wait");
        check("n15_grant", grant, 16'h8000);
        req = '0;
        wait_idle("n15_idle");

        // Full contention: every node served once in order, then node 0 again.
        for (int i = 0; i <= N; i++) exp_q.push_back(4'(i % N));
        t_log.delete();
        req = '1;
        n = 0;
        while (t_log.size() < N + 1 && n < 1600) begin
            step();
            n++;
        end
        req = '0;
        if (t_log.size() < N + 1) timeout_fail("contention_wait");
        wait_idle("contention_idle");
        n = 0;
        while (exp_q.size() > 0) begin
            logic [ADDR_W-1:0] e;
            logic [ADDR_W-1:0] g;
            e = exp_q.pop_front();
            g = (n < t_log.size()) ? t_log[n] : 4'bx;
            check($sformatf("contention_tx%0d", n), g, e);
            n++;
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
